// File: rtl/updown_mod_counter_pkg.sv
// Shared types and constants for the up/down modulo counter.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

endpackage

// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX_VAL+1) counter with wrap or saturate mode, clear, load and sticky overflow.
// Optional embedded properties enabled by defining UPDOWN_MOD_COUNTER_SVA_EN.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter cnt_mode_t       MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_mod_counter: WIDTH must be in 2..32");
    end
    if (MAX_VAL == 64'd0 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("updown_mod_counter: MAX_VAL must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_N = MAX_X[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   inc_x, dec_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // The extra bit makes the terminal compare and the decrement borrow explicit,
    // so a non-power-of-two MAX_VAL never relies on natural WIDTH-bit rollover.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        inc_x  = {1'b0, cnt_q} + (WIDTH+1)'(1);
        dec_x  = {1'b0, cnt_q} - (WIDTH+1)'(1);

        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            if ({1'b0, load_val} > MAX_X) begin
                cnt_d = MAX_N;
            end else begin
                cnt_d = load_val;
            end
        end else if (en) begin
            if (up_dn == CNT_UP) begin
                if (inc_x > MAX_X) begin
                    ovf_d = 1'b1;
                    if (MODE == CNT_WRAP) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = inc_x[WIDTH-1:0];
                end
            end else begin
                if (dec_x[WIDTH]) begin
                    ovf_d = 1'b1;
                    if (MODE == CNT_WRAP) begin
                        cnt_d  = MAX_N;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = dec_x[WIDTH-1:0];
                end
            end
        end
    end

    assign cnt  = cnt_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

`ifdef UPDOWN_MOD_COUNTER_SVA_EN
    logic past_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            past_valid_q <= 1'b0;
        end else begin
            past_valid_q <= 1'b1;
        end
    end

    a_range: assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, cnt_q} <= MAX_X)
        else $error("cnt exceeds MAX_VAL");

    a_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({cnt_q, wrap_q, ovf_q}))
        else $error("unknown value on counter outputs");

    a_up: assert property (@(posedge clk) disable iff (!rst_n)
        past_valid_q && $past(en && !clr && !load && (up_dn == CNT_UP)) |->
            ({1'b0, cnt_q} == {1'b0, $past(cnt_q)} + (WIDTH+1)'(1)) ||
            (($past(cnt_q) == MAX_N) && (cnt_q == '0 || cnt_q == MAX_N)))
        else $error("increment step violated");

    a_dn: assert property (@(posedge clk) disable iff (!rst_n)
        past_valid_q && $past(en && !clr && !load && (up_dn == CNT_DN)) |->
            ({1'b0, cnt_q} + (WIDTH+1)'(1) == {1'b0, $past(cnt_q)}) ||
            (($past(cnt_q) == '0) && (cnt_q == MAX_N || cnt_q == '0)))
        else $error("decrement step violated");

    a_wrap_val: assert property (@(posedge clk) disable iff (!rst_n)
        past_valid_q && wrap_q |->
            (($past(up_dn) == CNT_UP) ? (cnt_q == '0) : (cnt_q == MAX_N)))
        else $error("wrap pulse without boundary value");

    a_clr: assert property (@(posedge clk) disable iff (!rst_n)
        clr |=> (cnt_q == '0) && !ovf_q)
        else $error("clear did not zero counter");

    a_ovf_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        past_valid_q && $past(ovf_q) && !$past(clr) |-> ovf_q)
        else $error("overflow flag dropped without clear");

    c_wrap_up: cover property (@(posedge clk) disable iff (!rst_n)
        past_valid_q && wrap_q && ($past(up_dn) == CNT_UP));

    c_wrap_dn: cover property (@(posedge clk) disable iff (!rst_n)
        past_valid_q && wrap_q && ($past(up_dn) == CNT_DN));

    c_sat: cover property (@(posedge clk) disable iff (!rst_n)
        past_valid_q && (MODE == CNT_SAT) && $past(en && !clr && !load) &&
        (($past(up_dn) == CNT_UP) ? ($past(cnt_q) == MAX_N) : ($past(cnt_q) == '0)));
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter (WIDTH=4, MAX_VAL=9) share stimulus.
module tb_updown_mod_counter;
    import counter_pkg::*;

    localparam int W    = 4;
    localparam int MAXV = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] cnt_w, cnt_s;
    logic         wrap_w, wrap_s, ovf_w, ovf_s;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .MODE(CNT_WRAP)) u_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt_w), .wrap(wrap_w), .ovf(ovf_w)
    );

    updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .MODE(CNT_SAT)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt_s), .wrap(wrap_s), .ovf(ovf_s)
    );

    typedef struct { int cnt; bit wrap; bit ovf; } mstate_t;
    typedef struct { mstate_t w; mstate_t s; } exp_t;

    exp_t    expq[$];
    mstate_t mw, ms;
    int      checks = 0;
    int      passed = 0;

    // Reference: modular arithmetic over 0..MAXV, with out-of-range steps flagged.
    function automatic mstate_t model_step(mstate_t st, bit sat, bit c, bit l, int lv, bit e, bit u);
        mstate_t n;
        int nxt;
        n = st;
        n.wrap = 1'b0;
        if (c) begin
            n.cnt = 0;
            n.ovf = 1'b0;
        end else if (l) begin
            n.cnt = (lv > MAXV) ? MAXV : lv;
        end else if (e) begin
            nxt = u ? st.cnt + 1 : st.cnt - 1;
            if (nxt < 0 || nxt > MAXV) begin
                n.ovf = 1'b1;
                if (!sat) begin
                    n.cnt  = (nxt + MAXV + 1) % (MAXV + 1);
                    n.wrap = 1'b1;
                end
            end else begin
                n.cnt = nxt;
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    task automatic cycle(input bit c, input bit l, input int lv, input bit e, input bit u);
        @(negedge clk);
        #1;
        clr = c; load = l; load_val = W'(lv); en = e; up_dn = u;
        mw = model_step(mw, 1'b0, c, l, lv, e, u);
        ms = model_step(ms, 1'b1, c, l, lv, e, u);
        expq.push_back('{mw, ms});
    endtask

    // Asynchronous reset asserted mid-cycle; the monitor samples right after the falling rst_n.
    task automatic do_reset();
        @(negedge clk);
        #1;
        clr = 1'b0; load = 1'b0; en = 1'b0;
        mw = '{0, 1'b0, 1'b0};
        ms = '{0, 1'b0, 1'b0};
        expq.push_back('{mw, ms});
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("wrap_cnt",  int'(cnt_w),  e.w.cnt);
                chk("wrap_wrap", int'(wrap_w), int'(e.w.wrap));
                chk("wrap_ovf",  int'(ovf_w),  int'(e.w.ovf));
                chk("sat_cnt",   int'(cnt_s),  e.s.cnt);
                chk("sat_wrap",  int'(wrap_s), int'(e.s.wrap));
                chk("sat_ovf",   int'(ovf_s),  int'(e.s.ovf));
            end
        end
    end

    initial begin : stimulus
        int r;
        mw = '{0, 1'b0, 1'b0};
        ms = '{0, 1'b0, 1'b0};
        expq.push_back('{mw, ms});
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // up from 0 across the wrap
        repeat (12) cycle(0, 0, 0, 1, 1);
        // down from 0
        cycle(1, 0, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 1, 0);
        // saturate-mode hold at the top, starting from 7
        cycle(0, 1, 7, 0, 1);
        repeat (5) cycle(0, 0, 0, 1, 1);
        // clamped load beats enable, then clear beats load
        cycle(0, 1, 12, 1, 1);
        cycle(1, 1, 5, 1, 1);
        // async reset at cnt=5, then resume
        repeat (5) cycle(0, 0, 0, 1, 1);
        do_reset();
        cycle(0, 0, 0, 1, 1);
        // enable toggling with direction flips from 3
        cycle(0, 1, 3, 0, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        // wrap downward from 0 and saturate at 0
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                do_reset();
            end else begin
                cycle(r < 6, (r >= 6 && r < 16), int'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)));
            end
        end

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
